// File: rtl/fetch_queue_issue_unit_pkg.sv
// Shared constants and types for the fetch queue / issue unit.
// Covers RV32 opcodes, RVC encodings, queue entry layout and BHT counter helpers.
package fetch_queue_issue_unit_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] RVC_Q1   = 2'b01;
    localparam logic [1:0] RVC_Q2   = 2'b10;
    localparam logic [1:0] RVC_NONE = 2'b11;

    localparam logic [2:0] C1_JAL  = 3'b001;
    localparam logic [2:0] C1_J    = 3'b101;
    localparam logic [2:0] C1_BEQZ = 3'b110;
    localparam logic [2:0] C1_BNEZ = 3'b111;
    localparam logic [2:0] C2_JR   = 3'b100;

    typedef logic [1:0] bht_ctr_t;
    localparam bht_ctr_t BHT_RESET = 2'b01;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] ins;
        logic            is_compressed;
        logic [XLEN-1:0] predicted_pc;
        logic            pred_taken;
    } fq_entry_t;

    // Two-bit saturating counter step.
    function automatic bht_ctr_t bht_next(input bht_ctr_t ctr, input logic taken);
        bht_ctr_t res;
        res = ctr;
        if (taken && ctr != 2'b11) begin
            res = ctr + 2'(1);
        end else if (!taken && ctr != 2'b00) begin
            res = ctr - 2'(1);
        end
        return res;
    endfunction

endpackage

// File: rtl/rv_predecoder.sv
// Combinational predecode of one fetched word (RV32 or RVC): length,
// control-flow class and the PC-relative target for JAL/branch forms.
module rv_predecoder
    import fetch_queue_issue_unit_pkg::*;
(
    input  logic [XLEN-1:0] ins,
    input  logic [XLEN-1:0] pc,
    output logic [2:0]      len,
    output logic            is_jal,
    output logic            is_branch,
    output logic            is_jalr,
    output logic [XLEN-1:0] target
);

    logic [XLEN-1:0] imm_j;
    logic [XLEN-1:0] imm_b;
    logic [XLEN-1:0] imm_cj;
    logic [XLEN-1:0] imm_cb;
    logic [XLEN-1:0] imm;
    logic [1:0]      quad;
    logic [2:0]      c_funct3;

    assign quad     = ins[1:0];
    assign c_funct3 = ins[15:13];

    assign imm_j  = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    assign imm_b  = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    assign imm_cj = {{20{ins[12]}}, ins[12], ins[8], ins[10:9], ins[6], ins[7],
                     ins[2], ins[11], ins[5:3], 1'b0};
    assign imm_cb = {{23{ins[12]}}, ins[12], ins[6:5], ins[2], ins[11:10], ins[4:3], 1'b0};

    // Classify and select the immediate for the PC-relative forms.
    always_comb begin
        len       = 3'd4;
        is_jal    = 1'b0;
        is_branch = 1'b0;
        is_jalr   = 1'b0;
        imm       = '0;
        if (quad == RVC_NONE) begin
            case (ins[6:0])
                OP_JAL: begin
                    is_jal = 1'b1;
                    imm    = imm_j;
                end
                OP_BRANCH: begin
                    is_branch = 1'b1;
                    imm       = imm_b;
                end
                OP_JALR: is_jalr = 1'b1;
                default: ;
            endcase
        end else begin
            len = 3'd2;
            if (quad == RVC_Q1) begin
                case (c_funct3)
                    C1_JAL, C1_J: begin
                        is_jal = 1'b1;
                        imm    = imm_cj;
                    end
                    C1_BEQZ, C1_BNEZ: begin
                        is_branch = 1'b1;
                        imm       = imm_cb;
                    end
                    default: ;
                endcase
            end else if (quad == RVC_Q2) begin
                // C.JR / C.JALR: rs1 nonzero and rs2 zero; bit 12 picks link.
                if (c_funct3 == C2_JR && ins[11:7] != 5'd0 && ins[6:2] == 5'd0) begin
                    is_jalr = 1'b1;
                end
            end
        end
    end

    assign target = pc + imm;

endmodule

// File: rtl/fetch_queue_issue_unit.sv
// Fetch queue with predecode and 2-bit BHT prediction, decoupling the icache
// from issue through a circular queue and a valid/ready issue handshake.
module fetch_queue_issue_unit
    import fetch_queue_issue_unit_pkg::*;
#(
    parameter int unsigned FQ_DEPTH    = 8,
    parameter int unsigned BHT_ENTRIES = 64,
    parameter logic [31:0] RESET_PC    = 32'h0
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        flush_pipline,
    input  logic [31:0] reset_PC_to,
    input  logic        jalr_just_done,
    input  logic [31:0] jalr_resulting_PC,
    input  logic        bht_update_valid,
    input  logic [31:0] bht_update_pc,
    input  logic        bht_update_taken,
    output logic        icache_read_en,
    output logic [31:0] icache_read_addr,
    input  logic        icache_ready,
    input  logic [31:0] icache_read_data,
    output logic        issue_valid,
    input  logic        issue_ready,
    output logic [31:0] issue_PC,
    output logic [31:0] issue_ins,
    output logic        issue_is_compressed,
    output logic [31:0] issue_predicted_PC,
    output logic        issue_pred_taken
);

    localparam int unsigned IDX_W     = $clog2(FQ_DEPTH);
    localparam int unsigned PTR_W     = IDX_W + 1;
    localparam int unsigned BHT_IDX_W = $clog2(BHT_ENTRIES);

    localparam logic [0:0] ST_FETCH     = 1'b0;
    localparam logic [0:0] ST_WAIT_JALR = 1'b1;

    logic [0:0]       state, state_n;
    logic [31:0]      fetch_pc, fetch_pc_n;
    logic [PTR_W-1:0] wr_ptr, wr_ptr_n;
    logic [PTR_W-1:0] rd_ptr, rd_ptr_n;
    logic             read_en_q, read_en_n;
    logic             enq;

    fq_entry_t fq_mem [FQ_DEPTH];
    fq_entry_t new_entry;
    fq_entry_t head;
    bht_ctr_t  bht [BHT_ENTRIES];

    logic [2:0]  pd_len;
    logic        pd_is_jal;
    logic        pd_is_branch;
    logic        pd_is_jalr;
    logic [31:0] pd_target;
    logic [31:0] pc_plus_len;
    logic [31:0] pred_pc;
    logic        pred_taken;
    logic        is_rvc;
    logic        q_empty;

    logic [BHT_IDX_W-1:0] lookup_idx;
    logic [BHT_IDX_W-1:0] update_idx;
    logic                 unused_pc_bits;

    function automatic logic ptr_full(input logic [PTR_W-1:0] w, input logic [PTR_W-1:0] r);
        return (w[PTR_W-1] != r[PTR_W-1]) && (w[PTR_W-2:0] == r[PTR_W-2:0]);
    endfunction

    rv_predecoder u_predecoder (
        .ins       (icache_read_data),
        .pc        (fetch_pc),
        .len       (pd_len),
        .is_jal    (pd_is_jal),
        .is_branch (pd_is_branch),
        .is_jalr   (pd_is_jalr),
        .target    (pd_target)
    );

    assign lookup_idx     = fetch_pc[BHT_IDX_W:1];
    assign update_idx     = bht_update_pc[BHT_IDX_W:1];
    assign unused_pc_bits = ^{bht_update_pc[31:BHT_IDX_W+1], bht_update_pc[0]};

    // Prediction reads the pre-update counter even when an update hits the same index.
    assign is_rvc      = (pd_len == 3'd2);
    assign pc_plus_len = fetch_pc + 32'(pd_len);
    assign pred_taken  = pd_is_branch && bht[lookup_idx][1];
    assign pred_pc     = (pd_is_jal || pred_taken) ? pd_target : pc_plus_len;

    always_comb begin
        new_entry               = '0;
        new_entry.pc            = fetch_pc;
        new_entry.ins           = is_rvc ? {16'h0, icache_read_data[15:0]} : icache_read_data;
        new_entry.is_compressed = is_rvc;
        new_entry.predicted_pc  = pred_pc;
        new_entry.pred_taken    = pred_taken;
    end

    // Next-state: flush dominates; otherwise dequeue, fetch/enqueue and JALR resume.
    always_comb begin
        state_n    = state;
        fetch_pc_n = fetch_pc;
        wr_ptr_n   = wr_ptr;
        rd_ptr_n   = rd_ptr;
        read_en_n  = read_en_q;
        enq        = 1'b0;
        if (rdy_in) begin
            if (flush_pipline) begin
                state_n    = ST_FETCH;
                fetch_pc_n = reset_PC_to;
                wr_ptr_n   = '0;
                rd_ptr_n   = '0;
            end else begin
                if (issue_valid && issue_ready) begin
                    rd_ptr_n = rd_ptr + PTR_W'(1);
                end
                case (state)
                    ST_FETCH: begin
                        // read_en_q is only high while the queue has room.
                        if (read_en_q && icache_ready) begin
                            enq        = 1'b1;
                            wr_ptr_n   = wr_ptr + PTR_W'(1);
                            fetch_pc_n = pred_pc;
                            if (pd_is_jalr) begin
                                state_n = ST_WAIT_JALR;
                            end
                        end
                    end
                    ST_WAIT_JALR: begin
                        if (jalr_just_done) begin
                            state_n    = ST_FETCH;
                            fetch_pc_n = jalr_resulting_PC;
                        end
                    end
                    default: state_n = ST_FETCH;
                endcase
            end
            read_en_n = (state_n == ST_FETCH) && !ptr_full(wr_ptr_n, rd_ptr_n);
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state     <= ST_FETCH;
            fetch_pc  <= RESET_PC;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            read_en_q <= 1'b0;
        end else begin
            state     <= state_n;
            fetch_pc  <= fetch_pc_n;
            wr_ptr    <= wr_ptr_n;
            rd_ptr    <= rd_ptr_n;
            read_en_q <= read_en_n;
        end
    end

    // Queue storage needs no reset: contents are only visible through the pointers.
    always_ff @(posedge clk_in) begin
        if (!rst_in && enq) begin
            fq_mem[wr_ptr[IDX_W-1:0]] <= new_entry;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < int'(BHT_ENTRIES); i++) begin
                bht[i] <= BHT_RESET;
            end
        end else if (rdy_in && bht_update_valid) begin
            bht[update_idx] <= bht_next(bht[update_idx], bht_update_taken);
        end
    end

    assign q_empty = (wr_ptr == rd_ptr);
    assign head    = q_empty ? '0 : fq_mem[rd_ptr[IDX_W-1:0]];

    assign icache_read_en      = read_en_q;
    assign icache_read_addr    = fetch_pc;
    assign issue_valid         = !q_empty;
    assign issue_PC            = head.pc;
    assign issue_ins           = head.ins;
    assign issue_is_compressed = head.is_compressed;
    assign issue_predicted_PC  = head.predicted_pc;
    assign issue_pred_taken    = head.pred_taken;

endmodule

// File: tb/tb_fetch_queue_issue_unit.sv
// Directed bench for fetch_queue_issue_unit with a queue-based reference model
// compared every cycle, plus hand-computed literal expectations.
module tb_fetch_queue_issue_unit;

    logic        clk_in;
    logic        rst_in;
    logic        rdy_in;
    logic        flush_pipline;
    logic [31:0] reset_PC_to;
    logic        jalr_just_done;
    logic [31:0] jalr_resulting_PC;
    logic        bht_update_valid;
    logic [31:0] bht_update_pc;
    logic        bht_update_taken;
    logic        icache_read_en;
    logic [31:0] icache_read_addr;
    logic        icache_ready;
    logic [31:0] icache_read_data;
    logic        issue_valid;
    logic        issue_ready;
    logic [31:0] issue_PC;
    logic [31:0] issue_ins;
    logic        issue_is_compressed;
    logic [31:0] issue_predicted_PC;
    logic        issue_pred_taken;

    int checks = 0;
    int errors = 0;

    // Halfword-addressed instruction memory, 8 KB window.
    logic [15:0] hw [4096];

    fetch_queue_issue_unit #(
        .FQ_DEPTH    (8),
        .BHT_ENTRIES (64),
        .RESET_PC    (32'h0)
    ) dut (
        .clk_in              (clk_in),
        .rst_in              (rst_in),
        .rdy_in              (rdy_in),
        .flush_pipline       (flush_pipline),
        .reset_PC_to         (reset_PC_to),
        .jalr_just_done      (jalr_just_done),
        .jalr_resulting_PC   (jalr_resulting_PC),
        .bht_update_valid    (bht_update_valid),
        .bht_update_pc       (bht_update_pc),
        .bht_update_taken    (bht_update_taken),
        .icache_read_en      (icache_read_en),
        .icache_read_addr    (icache_read_addr),
        .icache_ready        (icache_ready),
        .icache_read_data    (icache_read_data),
        .issue_valid         (issue_valid),
        .issue_ready         (issue_ready),
        .issue_PC            (issue_PC),
        .issue_ins           (issue_ins),
        .issue_is_compressed (issue_is_compressed),
        .issue_predicted_PC  (issue_predicted_PC),
        .issue_pred_taken    (issue_pred_taken)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [11:0] i;
        i = a[12:1];
        return {hw[12'(i + 12'd1)], hw[i]};
    endfunction

    assign icache_read_data = mem_word(icache_read_addr);

    task automatic put_word(input logic [31:0] a, input logic [31:0] w);
        hw[a[12:1]]         = w[15:0];
        hw[a[12:1] + 12'd1] = w[31:16];
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
        logic [31:0] pred;
        bit          comp;
        bit          taken;
    } exp_t;

    exp_t        m_q[$];
    logic [31:0] m_pc;
    bit          m_wait;
    bit          m_en;
    int          m_bht [64];
    bit          model_live = 0;

    // Architectural meaning of one fetched word at pc.
    function automatic exp_t model_decode(input logic [31:0] w, input logic [31:0] pc,
                                          input int ctr, output bit jalr);
        exp_t e;
        logic [1:0] q;
        logic [2:0] f3;
        e.pc    = pc;
        e.comp  = (w[1:0] != 2'b11);
        e.ins   = e.comp ? {16'h0, w[15:0]} : w;
        e.pred  = pc + (e.comp ? 32'd2 : 32'd4);
        e.taken = 0;
        jalr    = 0;
        q       = w[1:0];
        f3      = w[15:13];
        if (!e.comp) begin
            if (w[6:0] == 7'h6F)
                e.pred = pc + {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
            else if (w[6:0] == 7'h63 && ctr >= 2) begin
                e.pred  = pc + {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
                e.taken = 1;
            end else if (w[6:0] == 7'h67)
                jalr = 1;
        end else if (q == 2'b01 && (f3 == 3'd1 || f3 == 3'd5)) begin
            e.pred = pc + {{20{w[12]}}, w[12], w[8], w[10:9], w[6], w[7], w[2], w[11], w[5:3], 1'b0};
        end else if (q == 2'b01 && f3 >= 3'd6 && ctr >= 2) begin
            e.pred  = pc + {{23{w[12]}}, w[12], w[6:5], w[2], w[11:10], w[4:3], 1'b0};
            e.taken = 1;
        end else if (q == 2'b10 && f3 == 3'd4 && w[11:7] != 0 && w[6:2] == 0) begin
            jalr = 1;
        end
        return e;
    endfunction

    always @(posedge clk_in) begin
        exp_t e;
        bit   j;
        int   ui;
        if (rst_in) begin
            m_q.delete();
            m_pc   = 32'h0;
            m_wait = 0;
            m_en   = 0;
            for (int i = 0; i < 64; i++) m_bht[i] = 1;
            model_live = 1;
        end else if (rdy_in) begin
            if (flush_pipline) begin
                m_q.delete();
                m_pc   = reset_PC_to;
                m_wait = 0;
            end else begin
                if (m_q.size() > 0 && issue_ready) void'(m_q.pop_front());
                if (!m_wait && m_en && icache_ready) begin
                    e = model_decode(mem_word(m_pc), m_pc, m_bht[(m_pc >> 1) & 63], j);
                    m_q.push_back(e);
                    m_pc = e.pred;
                    if (j) m_wait = 1;
                end else if (m_wait && jalr_just_done) begin
                    m_pc   = jalr_resulting_PC;
                    m_wait = 0;
                end
            end
            if (bht_update_valid) begin
                ui = int'((bht_update_pc >> 1) & 32'd63);
                if (bht_update_taken && m_bht[ui] < 3) m_bht[ui]++;
                else if (!bht_update_taken && m_bht[ui] > 0) m_bht[ui]--;
            end
            m_en = !m_wait && (m_q.size() < 8);
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk_in) begin
        if (model_live) begin
            chk("m_read_en", 32'(icache_read_en), 32'(m_en));
            if (m_en) chk("m_read_addr", icache_read_addr, m_pc);
            chk("m_issue_valid", 32'(issue_valid), 32'(m_q.size() > 0));
            if (m_q.size() > 0) begin
                chk("m_issue_pc", issue_PC, m_q[0].pc);
                chk("m_issue_ins", issue_ins, m_q[0].ins);
                chk("m_issue_comp", 32'(issue_is_compressed), 32'(m_q[0].comp));
                chk("m_issue_pred", issue_predicted_PC, m_q[0].pred);
                chk("m_issue_taken", 32'(issue_pred_taken), 32'(m_q[0].taken));
            end else begin
                chk("m_empty_pc", issue_PC, 32'h0);
                chk("m_empty_pred", issue_predicted_PC, 32'h0);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk_in);
        #2;
    endtask

    task automatic pop_chk(input logic [31:0] pc, input logic [31:0] pred, input logic taken);
        chk("lit_valid", 32'(issue_valid), 32'h1);
        chk("lit_pc", issue_PC, pc);
        chk("lit_pred", issue_predicted_PC, pred);
        chk("lit_taken", 32'(issue_pred_taken), 32'(taken));
        issue_ready = 1'b1;
        tick(1);
        issue_ready = 1'b0;
    endtask

    task automatic flush_to(input logic [31:0] a);
        reset_PC_to   = a;
        flush_pipline = 1'b1;
        tick(1);
        flush_pipline = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 4096; i += 2) begin
            hw[i]     = 16'h0013;
            hw[i + 1] = 16'h0000;
        end
        rst_in = 1'b1; rdy_in = 1'b1; flush_pipline = 1'b0; reset_PC_to = '0;
        jalr_just_done = 1'b0; jalr_resulting_PC = '0; bht_update_valid = 1'b0;
        bht_update_pc = '0; bht_update_taken = 1'b0; icache_ready = 1'b0; issue_ready = 1'b0;
        tick(3);
        chk("rst_read_en", 32'(icache_read_en), 32'h0);
        chk("rst_issue_valid", 32'(issue_valid), 32'h0);
        chk("rst_addr", icache_read_addr, 32'h0);

        // Straight-line fill to full, then drain exactly eight entries.
        rst_in = 1'b0;
        icache_ready = 1'b1;
        tick(12);
        chk("full_read_en", 32'(icache_read_en), 32'h0);
        chk("full_valid", 32'(issue_valid), 32'h1);
        icache_ready = 1'b0;
        issue_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("drain_pc", issue_PC, 32'(4 * i));
            tick(1);
        end
        issue_ready = 1'b0;
        chk("drain_empty", 32'(issue_valid), 32'h0);

        // Mixed RVC / 32-bit stream.
        hw[0] = 16'h0001; hw[1] = 16'h0013; hw[2] = 16'h0000; hw[3] = 16'h0001;
        flush_to(32'h0);
        icache_ready = 1'b1;
        tick(3);
        icache_ready = 1'b0;
        chk("rvc_comp0", 32'(issue_is_compressed), 32'h1);
        chk("rvc_ins0", issue_ins, 32'h0000_0001);
        pop_chk(32'h0, 32'h2, 1'b0);
        chk("rvc_comp1", 32'(issue_is_compressed), 32'h0);
        pop_chk(32'h2, 32'h6, 1'b0);
        pop_chk(32'h6, 32'h8, 1'b0);

        // BEQ x0,x0,-16 at 0x10: weak not-taken, same-cycle update, then taken.
        put_word(32'h10, 32'hFE00_08E3);
        flush_to(32'h10);
        icache_ready = 1'b1;
        tick(1);
        icache_ready = 1'b0;
        pop_chk(32'h10, 32'h14, 1'b0);
        flush_to(32'h10);
        icache_ready = 1'b1;
        bht_update_valid = 1'b1; bht_update_pc = 32'h10; bht_update_taken = 1'b1;
        tick(1);
        icache_ready = 1'b0;
        tick(1);
        bht_update_valid = 1'b0;
        pop_chk(32'h10, 32'h14, 1'b0);
        bht_update_valid = 1'b1; bht_update_taken = 1'b0;
        flush_to(32'h10);
        bht_update_valid = 1'b0;
        icache_ready = 1'b1;
        tick(1);
        icache_ready = 1'b0;
        pop_chk(32'h10, 32'h0, 1'b1);

        // JALR: stray resolve in FETCH is ignored; fetch stalls until resolve.
        put_word(32'h20, 32'h0000_8067);
        flush_to(32'h20);
        jalr_resulting_PC = 32'h999; jalr_just_done = 1'b1;
        tick(1);
        jalr_just_done = 1'b0;
        chk("jalr_ignored_addr", icache_read_addr, 32'h20);
        icache_ready = 1'b1;
        tick(3);
        chk("jalr_wait_en", 32'(icache_read_en), 32'h0);
        pop_chk(32'h20, 32'h24, 1'b0);
        jalr_resulting_PC = 32'h400; jalr_just_done = 1'b1;
        tick(1);
        jalr_just_done = 1'b0;
        chk("jalr_resume_en", 32'(icache_read_en), 32'h1);
        chk("jalr_resume_addr", icache_read_addr, 32'h400);
        tick(1);
        icache_ready = 1'b0;
        pop_chk(32'h400, 32'h404, 1'b0);

        // Full queue, pause, then flush colliding with icache_ready and issue.
        put_word(32'h220, 32'hDEAD_0013);
        put_word(32'h80, 32'h1000_006F);
        hw[12'h0C0] = 16'hA011;
        flush_to(32'h200);
        icache_ready = 1'b1;
        tick(10);
        chk("f_full_en", 32'(icache_read_en), 32'h0);
        rdy_in = 1'b0; flush_pipline = 1'b1; reset_PC_to = 32'h80; issue_ready = 1'b1;
        tick(3);
        chk("pause_pc", issue_PC, 32'h200);
        chk("pause_en", 32'(icache_read_en), 32'h0);
        rdy_in = 1'b1; flush_pipline = 1'b0;
        tick(1);
        issue_ready = 1'b0;
        chk("f_reopen_en", 32'(icache_read_en), 32'h1);
        chk("f_reopen_addr", icache_read_addr, 32'h220);
        flush_pipline = 1'b1; issue_ready = 1'b1;
        tick(1);
        flush_pipline = 1'b0; issue_ready = 1'b0; icache_ready = 1'b0;
        chk("flush_valid", 32'(issue_valid), 32'h0);
        chk("flush_addr", icache_read_addr, 32'h80);
        icache_ready = 1'b1;
        tick(2);
        icache_ready = 1'b0;
        pop_chk(32'h80, 32'h180, 1'b0);
        chk("cj_comp", 32'(issue_is_compressed), 32'h1);
        pop_chk(32'h180, 32'h184, 1'b0);
        chk("discard_empty", 32'(issue_valid), 32'h0);

        tick(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
